// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-to-UART readout block.
// Holds the FSM state encoding, the default sync byte and the frame geometry.
package fifo_uart_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND_HDR  = 2'd1;
  localparam logic [1:0] ST_SEND_BYTE = 2'd2;

  localparam logic [7:0]  HEADER_BYTE_DEF = 8'hA5;
  localparam int unsigned FRAME_BYTES     = 5;
  localparam int unsigned BITS_PER_BYTE   = 10;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/fifo_uart_readout_uart_tx.sv
// 8N1 UART transmitter, LSB first, idle high.
// done marks the last cycle of the stop bit; a start in that cycle chains the next byte with no gap.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       Rclk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        active_q, active_d;
  logic        bit_end;

  assign bit_end = active_q && (baud_q == 16'(CLKS_PER_BIT - 1));
  assign done    = bit_end && (bit_q == 4'd9);
  assign tx      = tx_q;

  // bit_q counts line bits: 0 = start, 1..8 = data, 9 = stop.
  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    data_d   = data_q;
    tx_d     = tx_q;
    active_d = active_q;
    if (start && (!active_q || done)) begin
      active_d = 1'b1;
      tx_d     = 1'b0;
      data_d   = data;
      bit_d    = 4'd0;
      baud_d   = 16'd0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_d = 16'd0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
          bit_d    = 4'd0;
        end else begin
          bit_d = bit_q + 4'd1;
          tx_d  = (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
        end
      end else begin
        baud_d = baud_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Rclk) begin
    if (!rst) begin
      baud_q   <= 16'd0;
      bit_q    <= 4'd0;
      data_q   <= 8'd0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/fifo_uart_readout.sv
// Pops 32-bit words from a first-word-fall-through FIFO and sends each one
// over UART as a 5-byte frame: HEADER_BYTE then the word, MSB byte first.
module fifo_uart_readout
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER_BYTE  = HEADER_BYTE_DEF
) (
  input  logic        Rclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] fifo_data,
  input  logic        fifo_empty,
  input  logic        fifo_readERR,
  output logic        ReadEN,
  output logic        uart_tx,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        rd_error
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        rd_err_q, rd_err_d;
  logic        capture;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;

  // FIFO handshake: the FIFO presents fifo_data whenever fifo_empty is low;
  // a pop happens only in a cycle where ReadEN is high, and ReadEN is only
  // raised in IDLE with enable high, the FIFO non-empty and reset released.
  assign capture = rst && (state_q == ST_IDLE) && enable && !fifo_empty;
  assign ReadEN  = capture;
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    frame_cnt_d = frame_cnt_q;
    tx_start    = 1'b0;
    tx_data     = HEADER_BYTE;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          word_d   = fifo_data;
          state_d  = ST_SEND_HDR;
          tx_start = 1'b1;
          tx_data  = HEADER_BYTE;
        end
      end
      ST_SEND_HDR: begin
        if (tx_done) begin
          state_d  = ST_SEND_BYTE;
          idx_d    = 2'd3;
          tx_start = 1'b1;
          tx_data  = word_byte(word_q, 2'd3);
        end
      end
      ST_SEND_BYTE: begin
        if (tx_done) begin
          if (idx_q == 2'd0) begin
            state_d     = ST_IDLE;
            idx_d       = 2'd3;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            idx_d    = idx_q - 2'd1;
            tx_start = 1'b1;
            tx_data  = word_byte(word_q, idx_q - 2'd1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rd_err_d = rd_err_q | fifo_readERR;
  end

  always_ff @(posedge Rclk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd3;
      word_q      <= 32'd0;
      frame_cnt_q <= 16'd0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      frame_cnt_q <= frame_cnt_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign rd_error    = rd_err_q;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .Rclk  (Rclk),
    .rst   (rst),
    .start (tx_start),
    .data  (tx_data),
    .tx    (uart_tx),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_fifo_uart_readout.sv
// Directed bench for fifo_uart_readout with CLKS_PER_BIT=4 and a queue-based
// first-word-fall-through FIFO model; line bits are checked cycle by cycle.
module tb_fifo_uart_readout;

  localparam int N = 4;
  localparam logic [7:0] HDR = 8'hA5;

  logic        Rclk;
  logic        rst;
  logic        enable;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_readERR;
  logic        ReadEN;
  logic        uart_tx;
  logic        busy;
  logic [15:0] frame_count;
  logic        rd_error;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  int          check_cnt;
  int          pass_cnt;
  int          fail_cnt;
  logic        rd_seen;
  logic        tx_s;
  logic        busy_s;

  fifo_uart_readout #(
    .CLKS_PER_BIT(N),
    .HEADER_BYTE (HDR)
  ) dut (
    .Rclk        (Rclk),
    .rst         (rst),
    .enable      (enable),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_readERR(fifo_readERR),
    .ReadEN      (ReadEN),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .frame_count (frame_count),
    .rd_error    (rd_error)
  );

  // clock
  initial begin
    Rclk = 1'b0;
    forever #5 Rclk = ~Rclk;
  end

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 32'd0 : fifo_q[0];
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // Sample outputs mid-cycle, then apply the FIFO pop just after the edge.
  task automatic tick();
    @(negedge Rclk);
    rd_seen = ReadEN;
    tx_s    = uart_tx;
    busy_s  = busy;
    @(posedge Rclk);
    #1;
    if (rd_seen && fifo_q.size() > 0) fifo_q.delete(0);
    refresh();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the 200 line cycles following a capture; optional enable drop or
  // read-error pulse at the start of byte position drop_k / err_k.
  task automatic send_check(input string tag, input logic [31:0] w, input int drop_k, input int err_k);
    logic [7:0]  exp_b;
    logic [39:0] exp40;
    logic [39:0] obs40;
    int          busy_bad;
    int          rd_bad;
    logic        v;
    busy_bad = 0;
    rd_bad   = 0;
    exp_q.push_back(HDR);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    for (int k = 0; k < 5; k++) begin
      if (k == drop_k) enable = 1'b0;
      if (k == err_k) fifo_readERR = 1'b1;
      exp_b = exp_q.pop_front();
      for (int b = 0; b < 10; b++) begin
        v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[b-1];
        for (int c = 0; c < N; c++) exp40[b*N+c] = v;
      end
      for (int s = 0; s < 40; s++) begin
        tick();
        obs40[s] = tx_s;
        if (!busy_s) busy_bad++;
        if (rd_seen) rd_bad++;
        if (k == err_k && s == 0) fifo_readERR = 1'b0;
      end
      check($sformatf("%s byte%0d line", tag, k), obs40, exp40);
    end
    check($sformatf("%s busy held", tag), busy_bad, 0);
    check($sformatf("%s no ReadEN in frame", tag), rd_bad, 0);
  endtask

  initial begin
    int bad_rd;
    int bad_tx;
    int bad_busy;
    check_cnt    = 0;
    pass_cnt     = 0;
    fail_cnt     = 0;
    rst          = 1'b0;
    enable       = 1'b1;
    fifo_readERR = 1'b0;
    refresh();
    push(32'h12345678);
    repeat (3) tick();

    // reset state, with a word waiting and enable high
    check("rst uart_tx", tx_s, 1);
    check("rst busy", busy_s, 0);
    check("rst ReadEN", rd_seen, 0);
    check("rst frame_count", frame_count, 0);
    check("rst rd_error", rd_error, 0);
    check("rst no pop", fifo_q.size(), 1);

    // first frame
    rst = 1'b1;
    tick();
    check("w0 capture", rd_seen, 1);
    check("w0 popped", fifo_q.size(), 0);
    send_check("w0", 32'h12345678, -1, -1);
    tick();
    check("w0 frame_count", frame_count, 1);
    check("w0 idle busy", busy_s, 0);
    check("w0 idle ReadEN", rd_seen, 0);

    // empty FIFO for 1000 cycles
    bad_rd = 0; bad_tx = 0; bad_busy = 0;
    repeat (1000) begin
      tick();
      if (rd_seen) bad_rd++;
      if (tx_s !== 1'b1) bad_tx++;
      if (busy_s) bad_busy++;
    end
    check("empty ReadEN", bad_rd, 0);
    check("empty uart_tx", bad_tx, 0);
    check("empty busy", bad_busy, 0);

    // three queued words, 201-cycle spacing
    push(32'hA1B2C3D4);
    push(32'h0BADF00D);
    push(32'h76543210);
    tick();
    check("q0 capture", rd_seen, 1);
    send_check("q0", 32'hA1B2C3D4, -1, -1);
    tick();
    check("q1 capture spacing", rd_seen, 1);
    send_check("q1", 32'h0BADF00D, -1, -1);
    tick();
    check("q2 capture spacing", rd_seen, 1);
    send_check("q2", 32'h76543210, -1, -1);
    tick();
    check("q idle ReadEN", rd_seen, 0);
    check("q frame_count", frame_count, 4);

    // enable dropped during byte index 2
    push(32'hDEADBEEF);
    push(32'hCAFEF00D);
    tick();
    check("en capture", rd_seen, 1);
    send_check("en", 32'hDEADBEEF, 2, -1);
    bad_rd = 0; bad_busy = 0;
    repeat (50) begin
      tick();
      if (rd_seen) bad_rd++;
      if (busy_s) bad_busy++;
    end
    check("en off ReadEN", bad_rd, 0);
    check("en off busy", bad_busy, 0);
    check("en off queue", fifo_q.size(), 1);
    check("en frame_count", frame_count, 5);
    enable = 1'b1;
    tick();
    check("en resume capture", rd_seen, 1);
    send_check("en2", 32'hCAFEF00D, -1, -1);
    tick();
    check("en2 frame_count", frame_count, 6);

    // one-cycle read error pulse during a frame
    push(32'h0F1E2D3C);
    tick();
    check("err capture", rd_seen, 1);
    check("err before", rd_error, 0);
    send_check("err", 32'h0F1E2D3C, -1, 1);
    check("err sticky", rd_error, 1);
    tick();
    check("err frame_count", frame_count, 7);
    repeat (20) tick();
    check("err still set", rd_error, 1);

    // reset during the header stop bit
    push(32'h11223344);
    push(32'h55667788);
    tick();
    check("rs capture", rd_seen, 1);
    repeat (37) tick();
    check("rs stop bit", tx_s, 1);
    rst = 1'b0;
    tick();
    tick();
    check("rs uart_tx", tx_s, 1);
    check("rs busy", busy_s, 0);
    check("rs ReadEN", rd_seen, 0);
    check("rs frame_count", frame_count, 0);
    check("rs rd_error", rd_error, 0);
    check("rs queue", fifo_q.size(), 1);
    rst = 1'b1;
    tick();
    check("rs2 capture", rd_seen, 1);
    send_check("rs2", 32'h55667788, -1, -1);
    tick();
    check("rs2 frame_count", frame_count, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
